// File: rtl/button_debouncer_pkg.sv
// Shared defaults for the board button debouncer, kept in step with the GPIO
// button register width and the SoC constants header.
package button_debouncer_pkg;

  localparam int unsigned N_BUTTONS_DEF       = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned CNT_W_DEF           = 16;

  // True when the terminal count (cycles-1) is representable in w bits.
  function automatic bit cnt_fits(input int unsigned cycles, input int unsigned w);
    if (cycles < 1 || cycles > 65535) return 1'b0;
    if (w >= 32) return 1'b1;
    return (cycles - 1) < (32'd1 << w);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, stable level,
// registered press/release pulses and a sticky press flag.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic clear_i,
  output logic stable_o,
  output logic pressed_o,
  output logic released_o,
  output logic latched_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             released_q, released_d;
  logic             latched_q, latched_d;

  always_comb begin
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    // Any sample matching the stable level discards all accumulated credit.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      stable_d   = sync2_q;
      cnt_d      = '0;
      pressed_d  = sync2_q;
      released_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A press arriving with a clear still sets the flag so no press is lost.
  always_comb begin
    latched_d = latched_q;
    if (pressed_q)    latched_d = 1'b1;
    else if (clear_i) latched_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stable_q   <= 1'b0;
      cnt_q      <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      latched_q  <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      latched_q  <= latched_d;
    end
  end

  assign stable_o   = stable_q;
  assign pressed_o  = pressed_q;
  assign released_o = released_q;
  assign latched_o  = latched_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BUTTONS raw board buttons into clean levels, edge pulses and
// sticky press flags for the GPIO block.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = N_BUTTONS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_BUTTONS-1:0] buttons_raw_i,
  input  logic [N_BUTTONS-1:0] clear_i,
  output logic [N_BUTTONS-1:0] buttons_o,
  output logic [N_BUTTONS-1:0] pressed_o,
  output logic [N_BUTTONS-1:0] released_o,
  output logic [N_BUTTONS-1:0] press_latched_o
);

  if (!cnt_fits(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cfg
    $error("button_debouncer: DEBOUNCE_CYCLES out of range or CNT_W too narrow");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .raw_i     (buttons_raw_i[i]),
      .clear_i   (clear_i[i]),
      .stable_o  (buttons_o[i]),
      .pressed_o (pressed_o[i]),
      .released_o(released_o[i]),
      .latched_o (press_latched_o[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: table of per-edge vectors for a clean press/clear/release,
// then hand-written bounce, glitch, simultaneous and mid-count reset sequences.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw, clr;
  logic [2:0] btn, prs, rel, lat;
  logic [2:0] btn1, prs1, rel1, lat1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_debouncer #(.N_BUTTONS(3), .DEBOUNCE_CYCLES(4), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .buttons_raw_i(raw), .clear_i(clr),
    .buttons_o(btn), .pressed_o(prs), .released_o(rel), .press_latched_o(lat)
  );

  // Minimum debounce length, checked only for its 2-edge latency.
  button_debouncer #(.N_BUTTONS(3), .DEBOUNCE_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .buttons_raw_i(raw), .clear_i(clr),
    .buttons_o(btn1), .pressed_o(prs1), .released_o(rel1), .press_latched_o(lat1)
  );

  typedef struct {
    logic [2:0] raw, clr, btn, prs, rel, lat, btn1;
  } vec_t;

  vec_t tbl[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [8:0] pat;
    logic [14:0] act, exp;

    //          raw     clr     btn     prs     rel     lat     btn1
    tbl[0]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[3]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[4]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[5]  = '{3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001};
    tbl[6]  = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001};
    tbl[7]  = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001};
    tbl[8]  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[9]  = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[10] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[11] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[12] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[13] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[14] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[15] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    tbl[16] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    rst_n = 1'b0; raw = 3'b000; clr = 3'b000;
    tick(); tick();
    chk("reset_btn", btn, 3'b000);
    chk("reset_pls", prs | rel, 3'b000);
    chk("reset_lat", lat, 3'b000);
    rst_n = 1'b1;

    // Clean press, clear, release; entry k is sampled just after edge k.
    for (int k = 0; k < 17; k++) begin
      raw = tbl[k].raw;
      clr = tbl[k].clr;
      tick();
      act = {btn, prs, rel, lat, btn1};
      exp = {tbl[k].btn, tbl[k].prs, tbl[k].rel, tbl[k].lat, tbl[k].btn1};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL vec%0d {btn,prs,rel,lat,btn1}: got %b expected %b", k, act, exp);
      end
    end
    clr = 3'b000;

    // Button 1 bounces 1,0,1,0 then holds; rise 5 edges after last 0->1.
    pat = 9'b111110101;
    for (int i = 0; i < 9; i++) begin
      raw = {1'b0, pat[i], 1'b0};
      tick();
      chk("bounce_btn", btn, 3'b000);
      chk("bounce_prs", prs, 3'b000);
    end
    tick();
    chk("bounce_rise_btn", btn, 3'b010);
    chk("bounce_rise_prs", prs, 3'b010);
    clr = 3'b010;
    tick();
    chk("press_vs_clear_lat", lat, 3'b010);
    chk("press_single", prs, 3'b000);
    clr = 3'b000;
    tick();
    chk("lat_hold", lat, 3'b010);

    // Button 2 goes stable 1, then a 3-cycle low glitch must not release it.
    raw = 3'b110;
    for (int i = 0; i < 5; i++) tick();
    chk("b2_pre_rise", btn, 3'b010);
    tick();
    chk("b2_rise_btn", btn, 3'b110);
    chk("b2_rise_prs", prs, 3'b100);
    for (int i = 0; i < 9; i++) begin
      raw = (i < 3) ? 3'b010 : 3'b110;
      tick();
      chk("glitch_btn", btn, 3'b110);
      chk("glitch_rel", rel, 3'b000);
    end

    raw = 3'b000;
    for (int i = 0; i < 5; i++) tick();
    chk("rel_pre_btn", btn, 3'b110);
    tick();
    chk("rel_btn", btn, 3'b000);
    chk("rel_pls", rel, 3'b110);
    tick();
    chk("rel_single", rel, 3'b000);

    // Clear held high keeps flags clear.
    chk("lat_before_clear", lat, 3'b110);
    clr = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clear_held_lat", lat, 3'b000);
    end
    clr = 3'b000;

    // All three buttons together.
    raw = 3'b111;
    for (int i = 0; i < 5; i++) tick();
    chk("all_pre_btn", btn, 3'b000);
    tick();
    chk("all_rise_btn", btn, 3'b111);
    chk("all_rise_prs", prs, 3'b111);
    tick();
    chk("all_prs_single", prs, 3'b000);
    chk("all_lat", lat, 3'b111);
    raw = 3'b000;
    for (int i = 0; i < 5; i++) tick();
    chk("all_pre_fall", btn, 3'b111);
    tick();
    chk("all_fall_btn", btn, 3'b000);
    chk("all_fall_rel", rel, 3'b111);
    tick();
    chk("all_rel_single", rel, 3'b000);

    // Reset while button 0 is at count 2 with button 2 already stable high.
    raw = 3'b100;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_btn", btn, 3'b100);
    raw = 3'b101;
    for (int i = 0; i < 4; i++) tick();
    chk("pending_btn", btn, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("async_rst_btn", btn, 3'b000);
    chk("async_rst_lat", lat, 3'b000);
    chk("async_rst_pls", prs | rel, 3'b000);
    tick();
    chk("held_rst_btn", btn, 3'b000);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_redebounce_wait", btn | prs, 3'b000);
    end
    tick();
    chk("rst_redebounce_btn", btn, 3'b101);
    chk("rst_redebounce_prs", prs, 3'b101);
    tick();
    chk("rst_redebounce_lat", lat, 3'b101);
    chk("rst_redebounce_single", prs, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
